// File: rtl/mux_arb_pkg.sv
// Shared state encoding and source identifiers for the two-requester bus arbiter.
package mux_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN_A = 2'd1,
      OWN_B = 2'd2
   } arb_state_t;

   localparam logic SRC_A = 1'b0;
   localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/mux2_bus.sv
// W-bit 2:1 bus mux carrying beat data and the last flag together.
module mux2_bus #(
   parameter int W = 4
) (
   input  logic [W-1:0] a_data,
   input  logic         a_last,
   input  logic [W-1:0] b_data,
   input  logic         b_last,
   input  logic         s,
   output logic [W-1:0] y_data,
   output logic         y_last
);

   assign y_data = s ? b_data : a_data;
   assign y_last = s ? b_last : a_last;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin packet arbiter owning the select of a shared 2:1 bus mux,
// with a per-grant beat cap so one requester cannot starve the other.
//
// state | meaning
// IDLE  | no grant held, no transfer, all readys low
// OWN_A | requester A owns the mux (sel=0), A beats pass to y
// OWN_B | requester B owns the mux (sel=1), B beats pass to y
module mux2_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int W         = 4,
   parameter int MAX_BEATS = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         a_valid,
   input  logic [W-1:0] a_data,
   input  logic         a_last,
   output logic         a_ready,
   input  logic         b_valid,
   input  logic [W-1:0] b_data,
   input  logic         b_last,
   output logic         b_ready,
   output logic         y_valid,
   output logic [W-1:0] y_data,
   output logic         y_last,
   input  logic         y_ready,
   output logic         sel,
   output logic         busy
);

   localparam int CW = $clog2(MAX_BEATS + 1);
   localparam logic [CW-1:0] CNT_TOP = CW'(MAX_BEATS - 1);

   arb_state_t    state_q, state_d;
   logic          sel_q, sel_d;
   logic          last_winner_q, last_winner_d;
   logic [CW-1:0] beat_cnt_q, beat_cnt_d;

   logic [W-1:0]  mux_data;
   logic          mux_last;

   mux2_bus #(.W(W)) u_mux (
      .a_data (a_data),
      .a_last (a_last),
      .b_data (b_data),
      .b_last (b_last),
      .s      (sel_q),
      .y_data (mux_data),
      .y_last (mux_last)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         sel_q         <= SRC_A;
         last_winner_q <= SRC_B;
         beat_cnt_q    <= '0;
      end else begin
         state_q       <= state_d;
         sel_q         <= sel_d;
         last_winner_q <= last_winner_d;
         beat_cnt_q    <= beat_cnt_d;
      end
   end

   // A release hands straight to the other side when it is waiting, so grants are back-to-back.
   always_comb begin
      state_d       = state_q;
      sel_d         = sel_q;
      last_winner_d = last_winner_q;
      beat_cnt_d    = beat_cnt_q;
      unique case (state_q)
         IDLE: begin
            if (a_valid && (!b_valid || last_winner_q == SRC_B)) begin
               state_d = OWN_A;
               sel_d   = SRC_A;
            end else if (b_valid) begin
               state_d = OWN_B;
               sel_d   = SRC_B;
            end
         end
         OWN_A: begin
            if (a_valid && y_ready) begin
               if (a_last || beat_cnt_q == CNT_TOP) begin
                  last_winner_d = SRC_A;
                  beat_cnt_d    = '0;
                  if (b_valid) begin
                     state_d = OWN_B;
                     sel_d   = SRC_B;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  beat_cnt_d = beat_cnt_q + CW'(1);
               end
            end
         end
         OWN_B: begin
            if (b_valid && y_ready) begin
               if (b_last || beat_cnt_q == CNT_TOP) begin
                  last_winner_d = SRC_B;
                  beat_cnt_d    = '0;
                  if (a_valid) begin
                     state_d = OWN_A;
                     sel_d   = SRC_A;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  beat_cnt_d = beat_cnt_q + CW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      y_valid = 1'b0;
      y_last  = 1'b0;
      a_ready = 1'b0;
      b_ready = 1'b0;
      busy    = (state_q != IDLE);
      sel     = sel_q;
      y_data  = mux_data;
      unique case (state_q)
         OWN_A: begin
            y_valid = a_valid;
            y_last  = mux_last;
            a_ready = y_ready;
         end
         OWN_B: begin
            y_valid = b_valid;
            y_last  = mux_last;
            b_ready = y_ready;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed bench for mux2_rr_arbiter: a vector table for the packet, tie and
// alternation cases, plus hand sequences for the beat cap, stalls and reset.
module tb_mux2_rr_arbiter;

   localparam int W  = 4;
   localparam int MB = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         a_valid, a_last, a_ready;
   logic [W-1:0] a_data;
   logic         b_valid, b_last, b_ready;
   logic [W-1:0] b_data;
   logic         y_valid, y_last, y_ready;
   logic [W-1:0] y_data;
   logic         sel, busy;

   always #5 clk = ~clk;

   mux2_rr_arbiter #(.W(W), .MAX_BEATS(MB)) dut (
      .clk     (clk),
      .rst     (rst),
      .a_valid (a_valid),
      .a_data  (a_data),
      .a_last  (a_last),
      .a_ready (a_ready),
      .b_valid (b_valid),
      .b_data  (b_data),
      .b_last  (b_last),
      .b_ready (b_ready),
      .y_valid (y_valid),
      .y_data  (y_data),
      .y_last  (y_last),
      .y_ready (y_ready),
      .sel     (sel),
      .busy    (busy)
   );

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic         r;
      logic         av;
      logic [W-1:0] ad;
      logic         al;
      logic         bv;
      logic [W-1:0] bd;
      logic         bl;
      logic         yr;
      logic [9:0]   ex;
   } vec_t;

   vec_t tbl[$];

   // Expected outputs packed as {y_valid, y_data, y_last, a_ready, b_ready, sel, busy}.
   function automatic logic [9:0] ex(logic yv, logic [3:0] yd, logic yl,
                                     logic ar, logic br, logic s, logic bz);
      return {yv, yd, yl, ar, br, s, bz};
   endfunction

   function automatic vec_t mk(logic r, logic av, logic [3:0] ad, logic al,
                               logic bv, logic [3:0] bd, logic bl, logic yr,
                               logic [9:0] e);
      vec_t v;
      v.r = r; v.av = av; v.ad = ad; v.al = al;
      v.bv = bv; v.bd = bd; v.bl = bl; v.yr = yr; v.ex = e;
      return v;
   endfunction

   // Drives one cycle of inputs just after a rising edge, checks at the falling edge.
   task automatic cyc(string nm, logic r, logic av, logic [3:0] ad, logic al,
                      logic bv, logic [3:0] bd, logic bl, logic yr, logic [9:0] e);
      logic [9:0] got;
      rst = r; a_valid = av; a_data = ad; a_last = al;
      b_valid = bv; b_data = bd; b_last = bl; y_ready = yr;
      @(negedge clk);
      got = {y_valid, y_data, y_last, a_ready, b_ready, sel, busy};
      total++;
      if (got !== e) begin
         bad++;
         $display("FAIL %s got=%b want=%b (yv,yd[3:0],yl,ar,br,sel,busy)", nm, got, e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; a_valid = 1'b0; a_data = '0; a_last = 1'b0;
      b_valid = 1'b0; b_data = '0; b_last = 1'b0; y_ready = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; a_valid = 1'b0; a_data = '0; a_last = 1'b0;
      b_valid = 1'b0; b_data = '0; b_last = 1'b0; y_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // A-only 3-beat packet
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, ex(0, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 1, ex(0, 1, 0, 0, 0, 0, 0)));
      tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 1, ex(1, 1, 0, 1, 0, 0, 1)));
      tbl.push_back(mk(0, 1, 2, 0, 0, 0, 0, 1, ex(1, 2, 0, 1, 0, 0, 1)));
      tbl.push_back(mk(0, 1, 3, 1, 0, 0, 0, 1, ex(1, 3, 1, 1, 0, 0, 1)));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, ex(0, 0, 0, 0, 0, 0, 0)));
      // both valid from reset, 2-beat packets, back-to-back hand-off
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, ex(0, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(mk(0, 1, 4, 0, 1, 8, 0, 1, ex(0, 4, 0, 0, 0, 0, 0)));
      tbl.push_back(mk(0, 1, 4, 0, 1, 8, 0, 1, ex(1, 4, 0, 1, 0, 0, 1)));
      tbl.push_back(mk(0, 1, 5, 1, 1, 8, 0, 1, ex(1, 5, 1, 1, 0, 0, 1)));
      tbl.push_back(mk(0, 0, 0, 0, 1, 8, 0, 1, ex(1, 8, 0, 0, 1, 1, 1)));
      tbl.push_back(mk(0, 0, 0, 0, 1, 9, 1, 1, ex(1, 9, 1, 0, 1, 1, 1)));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, ex(0, 0, 0, 0, 0, 1, 0)));
      // alternating single-beat packets, then a bubble while A owns, then tie after A
      tbl.push_back(mk(0, 1, 1, 1, 1, 2, 1, 1, ex(0, 2, 0, 0, 0, 1, 0)));
      tbl.push_back(mk(0, 1, 1, 1, 1, 2, 1, 1, ex(1, 1, 1, 1, 0, 0, 1)));
      tbl.push_back(mk(0, 1, 1, 1, 1, 2, 1, 1, ex(1, 2, 1, 0, 1, 1, 1)));
      tbl.push_back(mk(0, 1, 1, 1, 1, 2, 1, 1, ex(1, 1, 1, 1, 0, 0, 1)));
      tbl.push_back(mk(0, 1, 1, 1, 1, 2, 1, 1, ex(1, 2, 1, 0, 1, 1, 1)));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, ex(0, 0, 0, 1, 0, 0, 1)));
      tbl.push_back(mk(0, 1, 3, 1, 0, 0, 0, 1, ex(1, 3, 1, 1, 0, 0, 1)));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, ex(0, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(mk(0, 1, 6, 0, 1, 7, 0, 1, ex(0, 6, 0, 0, 0, 0, 0)));
      tbl.push_back(mk(0, 1, 6, 0, 1, 7, 0, 1, ex(1, 7, 0, 0, 1, 1, 1)));

      for (int i = 0; i < tbl.size(); i++)
         cyc($sformatf("tbl%0d", i), tbl[i].r, tbl[i].av, tbl[i].ad, tbl[i].al,
             tbl[i].bv, tbl[i].bd, tbl[i].bl, tbl[i].yr, tbl[i].ex);

      // beat cap: A streams without last, B waits; A cut after MB beats
      do_reset();
      cyc("cap.req", 0, 1, 1, 0, 1, 8, 0, 1, ex(0, 1, 0, 0, 0, 0, 0));
      for (int k = 1; k <= MB; k++)
         cyc($sformatf("cap.a%0d", k), 0, 1, 4'(k), 0, 1, 8, 0, 1,
             ex(1, 4'(k), 0, 1, 0, 0, 1));
      cyc("cap.b1", 0, 1, 5, 0, 1, 8, 0, 1, ex(1, 8, 0, 0, 1, 1, 1));
      cyc("cap.b2", 0, 1, 5, 0, 1, 9, 1, 1, ex(1, 9, 1, 0, 1, 1, 1));
      cyc("cap.a5", 0, 1, 5, 0, 0, 0, 0, 1, ex(1, 5, 0, 1, 0, 0, 1));
      cyc("cap.a6", 0, 1, 6, 0, 0, 0, 0, 1, ex(1, 6, 0, 1, 0, 0, 1));
      cyc("cap.hold", 0, 0, 0, 0, 0, 0, 0, 1, ex(0, 0, 0, 1, 0, 0, 1));

      // downstream stall mid-packet; counter must not advance while stalled
      do_reset();
      cyc("stall.req", 0, 1, 1, 0, 0, 0, 0, 1, ex(0, 1, 0, 0, 0, 0, 0));
      cyc("stall.a1", 0, 1, 1, 0, 0, 0, 0, 1, ex(1, 1, 0, 1, 0, 0, 1));
      cyc("stall.s1", 0, 1, 2, 0, 0, 0, 0, 0, ex(1, 2, 0, 0, 0, 0, 1));
      cyc("stall.s2", 0, 1, 2, 0, 0, 0, 0, 0, ex(1, 2, 0, 0, 0, 0, 1));
      cyc("stall.a2", 0, 1, 2, 0, 0, 0, 0, 1, ex(1, 2, 0, 1, 0, 0, 1));
      cyc("stall.a3", 0, 1, 3, 1, 0, 0, 0, 1, ex(1, 3, 1, 1, 0, 0, 1));
      cyc("stall.idle", 0, 0, 0, 0, 0, 0, 0, 1, ex(0, 0, 0, 0, 0, 0, 0));

      // reset asserted during B's second beat
      do_reset();
      cyc("rst.req", 0, 0, 0, 0, 1, 3, 0, 1, ex(0, 0, 0, 0, 0, 0, 0));
      cyc("rst.b1", 0, 0, 0, 0, 1, 3, 0, 1, ex(1, 3, 0, 0, 1, 1, 1));
      cyc("rst.b2", 1, 0, 0, 0, 1, 4, 0, 1, ex(1, 4, 0, 0, 1, 1, 1));
      cyc("rst.after", 0, 1, 7, 1, 1, 4, 0, 1, ex(0, 7, 0, 0, 0, 0, 0));
      cyc("rst.awins", 0, 1, 7, 1, 1, 4, 0, 1, ex(1, 7, 1, 1, 0, 0, 1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
